mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares one unified mem instance between instruction fetch and data load/store.
//  Sits between fetch/decode and the single memory port in the multi-cycle core.
//  Arbitrates with data-priority plus anti-starvation, sequences each access, and returns read data.
//  Uses a req/ready handshake per requester.
// PARAMETERS
//  MEM_LATENCY   1  cycles mem_* outputs are held before read data is captured (>=1)
//  STARVE_LIMIT  4  max consecutive data grants while if_req is pending (>=1)
// PORTS
//  clock               in   1   system clock
//  reset               in   1   synchronous, active-high reset
//  if_req              in   1   fetch request; held until if_ready
//  if_addr             in   32  fetch address (word access, unsigned)
//  if_ready            out  1   1-cycle pulse: if_rdata valid
//  if_rdata            out  32  fetched instruction
//  d_req               in   1   data request; held with all d_* fields until d_ready
//  d_addr              in   32  data address
//  d_wdata             in   32  store data
//  d_read_write        in   1   1=load, 0=store
//  d_access_size       in   2   ACCESS_SIZE_* code
//  d_unsigned          in   1   unsigned load
//  d_ready             out  1   1-cycle pulse: access complete; d_rdata valid for loads
//  d_rdata             out  32  load data
//  mem_address         out  32  to mem.address
//  mem_data_in         out  32  to mem.data_in
//  mem_read_write      out  1   to mem.read_write
//  mem_access_size     out  2   to mem.access_size
//  mem_unsigned_access out  1   to mem.unsigned_access
//  mem_data_out        in   32  from mem.data_out
//  busy                out  1   1 while state != IDLE
// BEHAVIOUR
//  - Reset values: state IDLE; if_ready=0; d_ready=0; if_rdata=0; d_rdata=0; busy=0.
//  - Reset values (mem side): mem_address=0; mem_data_in=0; mem_read_write=1; mem_access_size=ACCESS_SIZE_WORD; mem_unsigned_access=1.
//  - Reset values (counters): lat_cnt=0; starve_cnt=0.
//  - All mem_* outputs are registered. Outside ACCESS, mem_read_write=1, so no spurious stores occur.
//  - FSM: IDLE -> ACCESS -> RESP -> IDLE.
//  - IDLE: on an edge with if_req|d_req, pick a winner and latch its fields onto mem_*; lat_cnt=MEM_LATENCY-1; go ACCESS.
//  - Fetch grant drives: address=if_addr, read_write=1, size=WORD, unsigned=1, data_in=0.
//  - ACCESS: lat_cnt decrements each cycle. When lat_cnt==0: capture mem_data_out into the winner's rdata (loads/fetch only; a store leaves d_rdata unchanged); restore mem_read_write=1; assert the winner's ready; go RESP.
//  - RESP: ready is high for exactly this cycle; requests are ignored; next state IDLE.
//  - The requester drops or changes its req in the cycle after ready.
//  - Timing: request first seen in cycle 0 -> mem_* valid in cycles 1..MEM_LATENCY -> ready in cycle MEM_LATENCY+1.
//  - Throughput: one access per MEM_LATENCY+2 cycles.
//  - Arbitration: d_req wins over if_req, unless if_req && starve_cnt==STARVE_LIMIT, in which case fetch wins.
//  - starve_cnt updates at each grant: +1 (saturating) on a data grant while if_req=1; cleared on a fetch grant or when if_req=0.
//  - if_req and d_req high in the same IDLE cycle: this is a normal simultaneous case and is resolved by the rule above.
//  - Requests deasserted while ACCESS/RESP are not aborted; the access completes and ready still pulses.
//  - Reset mid-operation: return to IDLE immediately with reset values. The in-flight access is dropped and no ready pulses.
//  - A store already presented to mem before the reset edge may have completed.
//  - if_ready and d_ready are never high in the same cycle.
// TESTING
//  - Fetch only, MEM_LATENCY=1: if_req, if_addr=0x10, mem word 0x10=0x00500093.
//    -> mem_address=0x10 in cycle 1; if_ready=1, if_rdata=0x00500093 in cycle 2; busy 0 in cycle 3.
//  - Store then load: d_req store, d_addr=0x100, d_wdata=0xDEADBEEF, size WORD.
//    -> mem_read_write=0 only in cycle 1; d_ready in cycle 2.
//    Then load 0x100 -> d_rdata=0xDEADBEEF.
//  - Byte load signed: mem 0x200=0x80.
//    -> d_rdata=0xFFFFFF80; the same access with d_unsigned=1 -> 0x00000080.
//  - Contention, STARVE_LIMIT=4: if_req and d_req held high continuously.
//    -> grant order D,D,D,D,F,D,D,D,D,F; if_ready and d_ready never coincide.
//  - Reset mid-access, MEM_LATENCY=3: reset in cycle 2 of a load.
//    -> no d_ready; all outputs at reset values next cycle; a new request is served normally afterwards.
//  - Latency sweep MEM_LATENCY=1,2,4: a single fetch gives if_ready in cycle MEM_LATENCY+1, and mem_address is stable throughout ACCESS.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbiter sharing one memory port between instruction fetch and data load/store.
// Data has priority; a pending fetch is forced through after STARVE_LIMIT consecutive data grants.
module mem_arbiter #(
  parameter int unsigned MEM_LATENCY  = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic        d_read_write,
  input  logic [1:0]  d_access_size,
  input  logic        d_unsigned,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic        mem_read_write,
  output logic [1:0]  mem_access_size,
  output logic        mem_unsigned_access,
  input  logic [31:0] mem_data_out,
  output logic        busy
);

  localparam logic [1:0] ACCESS_SIZE_WORD = 2'b10;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam int unsigned LW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [LW-1:0] LAT_INIT   = LW'(MEM_LATENCY - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [1:0]    state_q, state_d;
  logic [LW-1:0] lat_cnt_q, lat_cnt_d;
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic          gnt_data_q, gnt_data_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic          mem_rw_q, mem_rw_d;
  logic [1:0]    mem_size_q, mem_size_d;
  logic          mem_uns_q, mem_uns_d;
  logic          if_ready_q, if_ready_d;
  logic          d_ready_q, d_ready_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic [31:0]   d_rdata_q, d_rdata_d;
  logic          fetch_win;

  always_comb begin
    state_d      = state_q;
    lat_cnt_d    = lat_cnt_q;
    starve_cnt_d = starve_cnt_q;
    gnt_data_d   = gnt_data_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_rw_d     = mem_rw_q;
    mem_size_d   = mem_size_q;
    mem_uns_d    = mem_uns_q;
    if_ready_d   = 1'b0;
    d_ready_d    = 1'b0;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    fetch_win    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (if_req || d_req) begin
          fetch_win  = if_req && (!d_req || (starve_cnt_q == STARVE_MAX));
          state_d    = S_ACCESS;
          lat_cnt_d  = LAT_INIT;
          gnt_data_d = !fetch_win;
          if (fetch_win) begin
            mem_addr_d   = if_addr;
            mem_wdata_d  = '0;
            mem_rw_d     = 1'b1;
            mem_size_d   = ACCESS_SIZE_WORD;
            mem_uns_d    = 1'b1;
            starve_cnt_d = '0;
          end else begin
            mem_addr_d   = d_addr;
            mem_wdata_d  = d_wdata;
            mem_rw_d     = d_read_write;
            mem_size_d   = d_access_size;
            mem_uns_d    = d_unsigned;
            // A data win with if_req pending implies starve_cnt_q < STARVE_MAX, so no overflow.
            starve_cnt_d = if_req ? starve_cnt_q + 1'b1 : '0;
          end
        end
      end
      S_ACCESS: begin
        if (lat_cnt_q == '0) begin
          if (gnt_data_q) begin
            if (mem_rw_q) d_rdata_d = mem_data_out;
            d_ready_d = 1'b1;
          end else begin
            if_rdata_d = mem_data_out;
            if_ready_d = 1'b1;
          end
          mem_rw_d = 1'b1;
          state_d  = S_RESP;
        end else begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      lat_cnt_q    <= '0;
      starve_cnt_q <= '0;
      gnt_data_q   <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_rw_q     <= 1'b1;
      mem_size_q   <= ACCESS_SIZE_WORD;
      mem_uns_q    <= 1'b1;
      if_ready_q   <= 1'b0;
      d_ready_q    <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      gnt_data_q   <= gnt_data_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_rw_q     <= mem_rw_d;
      mem_size_q   <= mem_size_d;
      mem_uns_q    <= mem_uns_d;
      if_ready_q   <= if_ready_d;
      d_ready_q    <= d_ready_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign if_ready            = if_ready_q;
  assign d_ready             = d_ready_q;
  assign if_rdata            = if_rdata_q;
  assign d_rdata             = d_rdata_q;
  assign mem_address         = mem_addr_q;
  assign mem_data_in         = mem_wdata_q;
  assign mem_read_write      = mem_rw_q;
  assign mem_access_size     = mem_size_q;
  assign mem_unsigned_access = mem_uns_q;
  assign busy                = (state_q != S_IDLE);

endmodule
